// File: rtl/vga_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_capture
// Brief    : Captures complete VGA frames (VSYNC/DE/RGB) into a DDR3 write FIFO
//            with frame framing pulses, line/frame counters and a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module vga_capture #(
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 320,
    parameter int BURST_LEN  = 400,
    parameter int FIFO_AFULL = 1020
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        cap_enable,
    input  logic        err_clr,
    input  logic        in_vsync,
    input  logic        in_de,
    input  logic [23:0] in_rgb,
    input  logic [9:0]  fifo_usedw,
    output logic        fifo_write,
    output logic [23:0] fifo_wdata,
    output logic        frame_start,
    output logic        img_end,
    output logic        burst_req,
    output logic        frame_err,
    output logic [8:0]  line_cnt,
    output logic [7:0]  frame_cnt
);

    localparam logic [8:0] c_img_w = 9'(IMG_W);
    localparam logic [8:0] c_img_h = 9'(IMG_H);
    localparam logic [9:0] c_burst = 10'(BURST_LEN);
    localparam logic [9:0] c_afull = 10'(FIFO_AFULL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_vs;
    logic        r_vs_d;
    logic        r_de;
    logic        r_de_d;
    logic [23:0] r_rgb;
    logic [8:0]  r_pix_cnt;
    logic        r_last_wr;

    logic        w_vs_rise;
    logic        w_vs_fall;
    logic        w_de_fall;
    logic        w_line_ok;
    logic        w_pix_ok;
    logic        w_room;
    logic        w_last_pix;
    logic        w_wr;
    logic        w_drop;
    logic        w_err_set;

    // Vsync history resets high so a source already mid-frame at reset
    // release cannot look like a fresh rising edge.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_vs   <= 1'b1;
            r_vs_d <= 1'b1;
            r_de   <= 1'b0;
            r_de_d <= 1'b0;
            r_rgb  <= '0;
        end else begin
            r_vs   <= in_vsync;
            r_vs_d <= r_vs;
            r_de   <= in_de;
            r_de_d <= r_de;
            r_rgb  <= in_rgb;
        end
    end

    assign w_vs_rise  = r_vs & ~r_vs_d;
    assign w_vs_fall  = ~r_vs & r_vs_d;
    assign w_de_fall  = ~r_de & r_de_d;
    assign w_line_ok  = (line_cnt < c_img_h);
    assign w_pix_ok   = (r_pix_cnt < c_img_w);
    assign w_room     = (fifo_usedw < c_afull);
    assign w_last_pix = (r_pix_cnt == (c_img_w - 9'd1)) && (line_cnt == (c_img_h - 9'd1));

    always_comb begin
        w_wr      = 1'b0;
        w_drop    = 1'b0;
        w_err_set = 1'b0;
        if (r_state == ACTIVE) begin
            if (r_de && w_line_ok) begin
                if (!w_pix_ok) begin
                    w_err_set = 1'b1;
                end else if (!w_room) begin
                    w_drop    = 1'b1;
                    w_err_set = 1'b1;
                end else begin
                    w_wr = 1'b1;
                end
            end
            if (w_de_fall && w_line_ok && (r_pix_cnt != c_img_w)) begin
                w_err_set = 1'b1;
            end
            // A frame whose final pixel lands together with vsync fall is complete.
            if (w_vs_fall && !(w_wr && w_last_pix)) begin
                w_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pix_cnt   <= '0;
            r_last_wr   <= 1'b0;
            fifo_write  <= 1'b0;
            fifo_wdata  <= '0;
            frame_start <= 1'b0;
            img_end     <= 1'b0;
            line_cnt    <= '0;
            frame_cnt   <= '0;
        end else begin
            fifo_write  <= 1'b0;
            frame_start <= 1'b0;
            r_last_wr   <= 1'b0;
            img_end     <= r_last_wr;
            if (r_last_wr) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            case (r_state)
                IDLE: begin
                    if (cap_enable) begin
                        r_state <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (!cap_enable) begin
                        r_state <= IDLE;
                    end else if (w_vs_rise) begin
                        r_state     <= ACTIVE;
                        frame_start <= 1'b1;
                        r_pix_cnt   <= '0;
                        line_cnt    <= '0;
                    end
                end
                ACTIVE: begin
                    if (w_wr) begin
                        fifo_write <= 1'b1;
                        fifo_wdata <= r_rgb;
                        r_pix_cnt  <= r_pix_cnt + 9'd1;
                    end
                    if (w_de_fall && w_line_ok) begin
                        r_pix_cnt <= '0;
                        line_cnt  <= line_cnt + 9'd1;
                    end
                    if (w_wr && w_last_pix) begin
                        // The last line's DE fall arrives after leaving ACTIVE.
                        r_last_wr <= 1'b1;
                        line_cnt  <= c_img_h;
                        r_state   <= cap_enable ? WAIT_VS : IDLE;
                    end else if (w_drop) begin
                        r_state <= DROP;
                    end else if (w_vs_fall) begin
                        r_state <= WAIT_VS;
                    end
                end
                DROP: begin
                    if (w_vs_fall) begin
                        r_state <= WAIT_VS;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            burst_req <= 1'b0;
        end else begin
            burst_req <= (fifo_usedw >= c_burst);
            if (w_err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
